// File: rtl/store_ctrl.sv
// ---------------------------------------------------------------------------
// store_ctrl
// Sequencer for the serial-to-parallel register store. It accepts serial
// bits under a valid/ready handshake and drives the store's active-low write
// strobe, data bit and bit-index address. When a word is complete it raises
// word_ready and refuses further input until the consumer acknowledges it.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start       in   begin/restart a word, clears overrun
//   rxvalid     in   serial bit valid
//   rxda        in   serial data bit
//   in_ready    out  a bit is accepted this cycle if rxvalid is high
//   oeenable    out  store write strobe, active-low
//   txda        out  data bit to store
//   ramadrs     out  {bit index, word_count}
//   word_ready  out  buffer holds a complete word
//   word_ack    in   consumer has taken the word
//   word_count  out  completed words, wraps modulo 2**(counter_size+1)
//   overrun     out  sticky: rxvalid seen while not ready (outside IDLE)
// ---------------------------------------------------------------------------
module store_ctrl #(
   parameter int unsigned counter_size = 4,
   parameter int unsigned buffer_size  = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      rxvalid,
   input  logic                      rxda,
   output logic                      in_ready,
   output logic                      oeenable,
   output logic                      txda,
   output logic [2*counter_size:0]   ramadrs,
   output logic                      word_ready,
   input  logic                      word_ack,
   output logic [counter_size:0]     word_count,
   output logic                      overrun
);

   localparam int unsigned IW = counter_size;
   localparam int unsigned WW = counter_size + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      FULL  = 2'd3
   } state_t;

   state_t          state_q,      state_d;
   logic [IW-1:0]   bit_idx_q,    bit_idx_d;
   logic [IW-1:0]   adr_idx_q,    adr_idx_d;
   logic [WW-1:0]   wc_q,         wc_d;
   logic            oe_q,         oe_d;
   logic            tx_q,         tx_d;
   logic            in_ready_q,   in_ready_d;
   logic            word_ready_q, word_ready_d;
   logic            overrun_q,    overrun_d;

   // State and output registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_idx_q    <= '0;
         adr_idx_q    <= '0;
         wc_q         <= '0;
         oe_q         <= 1'b1;
         tx_q         <= 1'b0;
         in_ready_q   <= 1'b0;
         word_ready_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_idx_q    <= bit_idx_d;
         adr_idx_q    <= adr_idx_d;
         wc_q         <= wc_d;
         oe_q         <= oe_d;
         tx_q         <= tx_d;
         in_ready_q   <= in_ready_d;
         word_ready_q <= word_ready_d;
         overrun_q    <= overrun_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      adr_idx_d = adr_idx_q;
      wc_d      = wc_q;
      oe_d      = 1'b1;          // strobe is low for exactly one cycle per bit
      tx_d      = tx_q;
      overrun_d = overrun_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = LOAD;
               bit_idx_d = '0;
            end
         end
         LOAD: begin
            if (start) begin
               // restart drops any bit offered in the same cycle
               state_d   = LOAD;
               bit_idx_d = '0;
               overrun_d = 1'b0;
            end else if (rxvalid && in_ready_q) begin
               oe_d      = 1'b0;
               tx_d      = rxda;
               adr_idx_d = bit_idx_q;
               bit_idx_d = bit_idx_q + IW'(1);
               if (bit_idx_q == IW'(buffer_size - 1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (start) begin
               state_d   = LOAD;
               bit_idx_d = '0;
               overrun_d = 1'b0;
            end else begin
               state_d = FULL;
               if (rxvalid) begin
                  overrun_d = 1'b1;
               end
            end
         end
         FULL: begin
            if (start) begin
               // start beats word_ack: the word is discarded, not counted
               state_d   = LOAD;
               bit_idx_d = '0;
               overrun_d = 1'b0;
            end else begin
               if (rxvalid) begin
                  overrun_d = 1'b1;
               end
               if (word_ack) begin
                  wc_d      = wc_q + WW'(1);
                  bit_idx_d = '0;
                  state_d   = LOAD;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      in_ready_d   = (state_d == LOAD);
      word_ready_d = (state_d == FULL);
   end

   assign in_ready   = in_ready_q;
   assign word_ready = word_ready_q;
   assign oeenable   = oe_q;
   assign txda       = tx_q;
   assign ramadrs    = {adr_idx_q, wc_q};
   assign word_count = wc_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_store_ctrl.sv
// ---------------------------------------------------------------------------
// tb_store_ctrl
// Self-checking bench for store_ctrl: directed scenarios followed by random
// stimulus, checked every cycle against a behavioural model of the word
// assembly, plus a model of the store that captures strobed bits.
// ---------------------------------------------------------------------------
module tb_store_ctrl;

   logic       clock = 1'b0;
   logic       reset;
   logic       start, rxvalid, rxda, word_ack;
   logic       in_ready, oeenable, txda, word_ready, overrun;
   logic [8:0] ramadrs;
   logic [4:0] word_count;

   int total = 0;
   int bad   = 0;

   store_ctrl #(.counter_size(4), .buffer_size(16)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .rxvalid   (rxvalid),
      .rxda      (rxda),
      .in_ready  (in_ready),
      .oeenable  (oeenable),
      .txda      (txda),
      .ramadrs   (ramadrs),
      .word_ready(word_ready),
      .word_ack  (word_ack),
      .word_count(word_count),
      .overrun   (overrun)
   );

   always #5 clock = ~clock;

   // Behavioural model: word assembly described by bit count and phase flags
   bit          m_acc, m_drain, m_full, m_ovr, m_oe, m_tx, full_rise;
   int          m_cnt, m_wc, m_idx;
   logic [15:0] mword;

   // Store model fed by the DUT's registered strobe
   logic [15:0] sbuf;
   logic        pend_oe, pend_tx;
   logic [3:0]  pend_idx;
   bit          chk_en = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_drain = 0; m_full = 0; m_ovr = 0; m_oe = 1; m_tx = 0;
      m_cnt = 0; m_wc = 0; m_idx = 0; full_rise = 0;
      pend_oe = 1'b1; pend_tx = 1'b0; pend_idx = '0;
   endtask

   task automatic model_step();
      bit was_full;
      was_full = m_full;
      m_oe = 1;
      if (start) begin
         m_acc = 1; m_drain = 0; m_full = 0; m_cnt = 0; m_ovr = 0;
      end else if (m_acc) begin
         if (rxvalid) begin
            m_oe = 0; m_tx = rxda; m_idx = m_cnt;
            mword[m_cnt] = rxda;
            m_cnt++;
            if (m_cnt == 16) begin
               m_acc = 0; m_drain = 1;
            end
         end
      end else if (m_drain) begin
         m_drain = 0; m_full = 1;
         if (rxvalid) m_ovr = 1;
      end else if (m_full) begin
         if (rxvalid) m_ovr = 1;
         if (word_ack) begin
            m_wc = (m_wc + 1) % 32;
            m_full = 0; m_acc = 1; m_cnt = 0;
         end
      end
      full_rise = m_full && !was_full;
   endtask

   // One clock: drive inputs, let the store and model advance on the edge
   task automatic cyc(input logic s, input logic v, input logic d, input logic a);
      start = s; rxvalid = v; rxda = d; word_ack = a;
      @(posedge clock);
      if (pend_oe === 1'b0) sbuf[pend_idx] = pend_tx;
      if (!reset) model_reset();
      else        model_step();
      #1;
      if (full_rise) chk("store_word", int'(sbuf), int'(mword));
   endtask

   // Compare process: every output against the model, away from the edge
   always @(negedge clock) begin
      if (chk_en) begin
         chk("in_ready",   int'(in_ready),   int'(m_acc));
         chk("word_ready", int'(word_ready), int'(m_full));
         chk("oeenable",   int'(oeenable),   int'(m_oe));
         chk("txda",       int'(txda),       int'(m_tx));
         chk("ramadrs",    int'(ramadrs),    ((m_idx & 15) << 5) | m_wc);
         chk("word_count", int'(word_count), m_wc);
         chk("overrun",    int'(overrun),    int'(m_ovr));
      end
      pend_oe  = oeenable;
      pend_tx  = txda;
      pend_idx = ramadrs[8:5];
   end

   task automatic send_word(input logic [15:0] w);
      for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1, w[i], 1'b0);
   endtask

   logic [15:0] pat;

   initial begin
      reset = 1'b0; start = 0; rxvalid = 0; rxda = 0; word_ack = 0;
      sbuf = '0; mword = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_oeenable", int'(oeenable),  1);
      chk("rst_ramadrs",  int'(ramadrs),   0);
      chk("rst_in_ready", int'(in_ready),  0);
      reset = 1'b1;
      chk_en = 1;

      // 1: one word 0xA5C3, LSB first, back to back
      cyc(1, 0, 0, 0);
      chk("t1_in_ready", int'(in_ready), 1);
      pat = 16'hA5C3;
      send_word(pat);
      chk("t1_last_strobe", int'(oeenable), 0);
      chk("t1_last_idx",    int'(ramadrs[8:5]), 15);
      chk("t1_drain_rdy",   int'(in_ready), 0);
      cyc(0, 0, 0, 0);
      chk("t1_word_ready",  int'(word_ready), 1);
      chk("t1_buffer",      int'(sbuf), 16'hA5C3);

      // 2: acknowledge
      cyc(0, 0, 0, 1);
      chk("t2_word_ready", int'(word_ready), 0);
      chk("t2_word_count", int'(word_count), 1);
      chk("t2_adr_low",    int'(ramadrs[4:0]), 1);
      chk("t2_in_ready",   int'(in_ready), 1);

      // 3: rxvalid held in FULL
      send_word(16'h3C5A);
      cyc(0, 0, 0, 0);
      repeat (3) cyc(0, 1, 1, 0);
      chk("t3_overrun", int'(overrun), 1);
      chk("t3_strobe",  int'(oeenable), 1);
      cyc(1, 0, 0, 0);
      chk("t3_ovr_clr", int'(overrun), 0);

      // 4: restart after 7 bits
      for (int i = 0; i < 7; i++) cyc(0, 1, 1'(i), 0);
      cyc(1, 0, 0, 0);
      chk("t4_word_count", int'(word_count), 1);
      for (int i = 0; i < 15; i++) cyc(0, 1, 1'(i >> 1), 0);
      chk("t4_not_ready", int'(word_ready), 0);
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);
      chk("t4_ready", int'(word_ready), 1);

      // 5: word_count wraps after 32 words
      reset = 1'b0; #1; model_reset();
      @(negedge clock); reset = 1'b1;
      cyc(1, 0, 0, 0);
      for (int w = 0; w < 32; w++) begin
         send_word(16'($urandom));
         cyc(0, 0, 0, 0);
         cyc(0, 0, 0, 1);
         if (w == 30) chk("t5_count31", int'(word_count), 31);
      end
      chk("t5_wrap", int'(word_count), 0);

      // 6: asynchronous reset mid-word with rxvalid high
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0);
      #1; reset = 1'b0; model_reset();
      #1;
      chk("t6_oeenable", int'(oeenable),   1);
      chk("t6_ramadrs",  int'(ramadrs),    0);
      chk("t6_in_ready", int'(in_ready),   0);
      chk("t6_txda",     int'(txda),       0);
      reset = 1'b1;

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         cyc(($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 75) ? 1'b1 : 1'b0,
             1'($urandom),
             ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0);
      end

      @(negedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
